// File: rtl/link_arb_pkg.sv
// Shared types and default constants for the round-robin link arbiter.
package link_arb_pkg;

    localparam int NUM_REQ     = 4;
    localparam int DW          = 4;
    localparam int BURST_MAX   = 4;
    localparam int TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/link_arb_if.sv
// Requester/receiver bundle of the link arbiter; slave is the arbiter side.
interface link_arb_if #(
    parameter int NUM_REQ = link_arb_pkg::NUM_REQ,
    parameter int DW      = link_arb_pkg::DW
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ*DW-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_last_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic                  valid_o;
    logic [DW-1:0]         data_o;
    logic                  busy_o;
    logic                  ready_i;
    logic [NUM_REQ-1:0]    grant_o;
    logic                  timeout_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, ready_i,
        output req_ready_o, valid_o, data_o, busy_o, grant_o, timeout_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, ready_i,
        input  req_ready_o, valid_o, data_o, busy_o, grant_o, timeout_o
    );
endinterface

// File: rtl/link_arb_rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping.
module rr_picker #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [N-1:0]    win_o,
    output logic            any_o
);
    logic            found;
    logic [IDXW-1:0] idx;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IDXW'((int'(last_i) + off) % N);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/link_arbiter.sv
// Round-robin burst arbiter sharing one rx link among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to force release of a grant stalled for TIMEOUT_CYC cycles.
module link_arbiter #(
    parameter int NUM_REQ     = link_arb_pkg::NUM_REQ,
    parameter int DW          = link_arb_pkg::DW,
    parameter int BURST_MAX   = link_arb_pkg::BURST_MAX,
    parameter int TIMEOUT_CYC = link_arb_pkg::TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    link_arb_if.slave  bus
);
    import link_arb_pkg::*;

    localparam int IDXW = idx_width(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]     gidx_q, gidx_d;
    logic [IDXW-1:0]     last_q, last_d;
    logic [3:0]          cnt_q, cnt_d, cnt_inc;

    logic [NUM_REQ-1:0]  pick_oh;
    logic                pick_any;
    logic [IDXW-1:0]     pick_idx;

    logic [DW-1:0]       data_arr [NUM_REQ];
    logic                valid_w, busy_w, timeout_w, beat, stall_hit;
    logic [DW-1:0]       data_w;
    logic [NUM_REQ-1:0]  ready_w;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_arr[gi] = bus.req_data_i[gi*DW +: DW];
        end
    endgenerate

    rr_picker #(.N(NUM_REQ), .IDXW(IDXW)) u_picker (
        .req_i  (bus.req_valid_i),
        .last_i (last_q),
        .win_o  (pick_oh),
        .any_o  (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_idx = IDXW'(i);
        end
    end

    assign cnt_inc = cnt_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDXW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = XFER;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (beat) cnt_d = cnt_inc;
                // A burst ends on its marked last beat, on the BURST_MAX-th beat, or on stall timeout.
                if ((beat && (bus.req_last_i[gidx_q] || cnt_inc == 4'(BURST_MAX))) || stall_hit) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    last_d  = gidx_q;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid_w = 1'b0;
        data_w  = '0;
        ready_w = '0;
        busy_w  = 1'b1;
        if (state_q == XFER) begin
            valid_w          = bus.req_valid_i[gidx_q];
            data_w           = data_arr[gidx_q];
            ready_w[gidx_q]  = bus.ready_i;
            busy_w           = 1'b0;
        end
    end

    assign beat = valid_w & bus.ready_i;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] stall_q, stall_d;
    logic       timeout_q;

    always_comb begin
        stall_d   = '0;
        stall_hit = 1'b0;
        if (state_q == XFER && !beat) begin
            stall_d   = stall_q + 8'd1;
            stall_hit = (stall_d == 8'(TIMEOUT_CYC));
        end
    end

    // The pulse lands in the RELEASE cycle that the timeout caused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= stall_hit;
        end
    end

    assign timeout_w = timeout_q;
`else
    assign stall_hit = 1'b0;
    assign timeout_w = 1'b0;
`endif

    assign bus.valid_o     = valid_w;
    assign bus.data_o      = data_w;
    assign bus.req_ready_o = ready_w;
    assign bus.busy_o      = busy_w;
    assign bus.grant_o     = grant_q;
    assign bus.timeout_o   = timeout_w;

    assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q) && ((ready_w & ~grant_q) == '0)
        && (BURST_MAX >= 1) && (BURST_MAX <= 15)
        && (TIMEOUT_CYC >= 2) && (TIMEOUT_CYC <= 255));

endmodule

// File: tb/tb_link_arbiter.sv
// Randomized scoreboard bench for link_arbiter; honours ARB_TIMEOUT_EN if defined.
module tb_link_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 4;
    localparam int BM  = 4;
    localparam int TO  = 16;
    localparam int DBW = NR * DW;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    link_arb_if #(.NUM_REQ(NR), .DW(DW)) bus ();

    link_arbiter #(.NUM_REQ(NR), .DW(DW), .BURST_MAX(BM), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NR-1:0] grant;
        logic [NR-1:0] ready;
        logic          valid;
        logic [DW-1:0] data;
        logic          busy;
        logic          timeout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   started = 1'b0;
    bit   done = 1'b0;

    // Reference model: owner/phase bookkeeping taken straight from the arbitration rules.
    int m_phase, m_owner, m_last, m_beats, m_stall;
    bit m_tout;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = NR - 1;
        m_beats = 0; m_stall = 0; m_tout = 1'b0;
    endtask

    task automatic model_step(input logic [NR-1:0] v, input logic [DBW-1:0] d,
                              input logic [NR-1:0] l, input logic rdy, input logic rst,
                              output exp_t e);
        bit found;
        e.grant = '0; e.ready = '0; e.valid = 1'b0; e.data = '0; e.busy = 1'b1; e.timeout = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        e.timeout = m_tout;
        if (m_phase == 1) begin
            e.grant[m_owner] = 1'b1;
            e.ready[m_owner] = rdy;
            e.valid          = v[m_owner];
            e.data           = d[m_owner*DW +: DW];
            e.busy           = 1'b0;
        end
        case (m_phase)
            0: begin
                m_tout = 1'b0;
                if (v != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NR; k++) begin
                        if (!found && v[(m_last + k) % NR]) begin
                            m_owner = (m_last + k) % NR;
                            found = 1'b1;
                        end
                    end
                    m_phase = 1; m_beats = 0; m_stall = 0;
                end
            end
            1: begin
                if (v[m_owner] && rdy) begin
                    m_beats++;
                    m_stall = 0;
                    if (l[m_owner] || m_beats == BM) begin
                        m_phase = 2; m_last = m_owner;
                    end
                end else begin
                    m_stall++;
                    if (TO_EN && m_stall == TO) begin
                        m_phase = 2; m_last = m_owner; m_tout = 1'b1;
                    end
                end
            end
            default: begin
                m_phase = 0; m_tout = 1'b0;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() == 0) begin
                if (!done) begin
                    n_bad++;
                    $display("FAIL scoreboard_empty: got 0 records, expected 1 at t=%0t", $time);
                end
            end else begin
                mon_e = exp_q.pop_front();
                n_vec++;
                chk("grant_o",     32'(bus.grant_o),     32'(mon_e.grant));
                chk("req_ready_o", 32'(bus.req_ready_o), 32'(mon_e.ready));
                chk("valid_o",     32'(bus.valid_o),     32'(mon_e.valid));
                chk("data_o",      32'(bus.data_o),      32'(mon_e.data));
                chk("busy_o",      32'(bus.busy_o),      32'(mon_e.busy));
                chk("timeout_o",   32'(bus.timeout_o),   32'(mon_e.timeout));
                chk("grant_onehot0", 32'($onehot0(bus.grant_o)), 32'd1);
                chk("ready_subset",  32'(bus.req_ready_o & ~bus.grant_o), 32'd0);
                chk("busy_vs_owner", 32'(bus.busy_o), 32'(bus.grant_o == '0));
                if (bus.valid_o && bus.ready_i)
                    $display("beat t=%0t grant=%b data=%h", $time, bus.grant_o, bus.data_o);
                if (bus.timeout_o)
                    $display("timeout t=%0t", $time);
            end
        end
    end

    int seg_mode [9] = '{6, 0, 1, 2, 3, 4, 5, 0, 4};
    int seg_len  [9] = '{3, 32, 16, 24, 24, 300, 14, 12, 200};

    initial begin
        logic [NR-1:0]  v, l;
        logic [DBW-1:0] d;
        logic           rdy, rst;
        exp_t           e;
        int             drop;
        bit             fired;

        rst_n = 1'b1;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        bus.ready_i     = 1'b0;
        model_reset();
        fired = 1'b0;

        for (int s = 0; s < 9; s++) begin
            drop = 0;
            for (int c = 0; c < seg_len[s]; c++) begin
                @(posedge clk);
                #1;
                v = '0; l = '0; rdy = 1'b1; rst = 1'b1;
                d = DBW'($urandom);
                case (seg_mode[s])
                    6: begin rst = 1'b0; v = NR'($urandom); end
                    0: v = '1;
                    1: begin
                        v = 4'b0100;
                        d[2*DW +: DW] = 4'hA;
                        l[2] = (m_phase == 1 && m_beats == 1);
                    end
                    2: begin
                        v = 4'b0010;
                        if (m_phase == 1 && m_owner == 1 && m_beats == 2 && drop < 3) begin
                            v = '0;
                            drop++;
                        end
                    end
                    3: begin v = '1; rdy = 1'b0; end
                    4: begin
                        v   = NR'($urandom);
                        l   = NR'($urandom) & NR'($urandom);
                        rdy = ($urandom_range(0, 3) != 0);
                    end
                    default: begin
                        v = '1;
                        if (!fired && m_phase == 1 && m_beats == 1) begin
                            rst   = 1'b0;
                            fired = 1'b1;
                        end
                    end
                endcase
                rst_n           = rst;
                bus.req_valid_i = v;
                bus.req_data_i  = d;
                bus.req_last_i  = l;
                bus.ready_i     = rdy;
                model_step(v, d, l, rdy, rst, e);
                exp_q.push_back(e);
                started = 1'b1;
            end
        end
        done = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d records left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/link_arbiter.md
LINK_ARBITER -- requirements
Module: link_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of transmit requesters sharing the rx link.
REQ-002 Parameter DW, default 4: data width of each requester and the link.
REQ-003 Parameter BURST_MAX, default 4: maximum beats per grant, range 1..15.
REQ-004 Parameter TIMEOUT_CYC, default 16: stall cycles before forced release, range 2..255; used only with ARB_TIMEOUT_EN.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid_i  input  NUM_REQ  per-requester data valid.
REQ-008 req_data_i  input  NUM_REQ*DW  requester i data in bits [i*DW +: DW].
REQ-009 req_last_i  input  NUM_REQ  marks final beat of requester burst.
REQ-010 req_ready_o  output  NUM_REQ  per-requester accept.
REQ-011 valid_o  output  1  link data valid toward receiver.
REQ-012 data_o  output  DW  link data toward receiver.
REQ-013 busy_o  output  1  drives receiver busy input.
REQ-014 ready_i  input  1  receiver ready.
REQ-015 grant_o  output  NUM_REQ  one-hot current owner, all-zero when unowned.
REQ-016 timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-017 The FSM SHALL have states IDLE, XFER and RELEASE.
REQ-018 IDLE: any req_valid_i high -> register one-hot grant and go to XFER next cycle, giving 1-cycle grant latency.
REQ-019 Selection SHALL be round-robin: first valid requester strictly after last_grant, wrapping NUM_REQ-1 -> 0.
REQ-020 XFER: valid_o = req_valid_i[g]; data_o = slice g; req_ready_o[g] = ready_i; all other req_ready_o bits 0.
REQ-021 A beat is valid_o & ready_i; the beat counter SHALL increment only on a beat.
REQ-022 XFER -> RELEASE on a beat with req_last_i[g]=1, or on the beat that brings the count to BURST_MAX.
REQ-023 Granted requester dropping valid mid-burst: grant held, valid_o 0, counter unchanged.
REQ-024 RELEASE: lasts exactly 1 cycle; grant_o cleared; last_grant <= g; counter cleared; -> IDLE.
REQ-025 busy_o SHALL be 0 only in XFER and 1 otherwise; receiver ready lag of 1 cycle is tolerated because beats require ready_i.
REQ-026 Outside XFER: valid_o=0, data_o=0, req_ready_o=0.
REQ-027 A sole active requester SHALL be re-granted after RELEASE, so back-to-back grants are separated by RELEASE and IDLE.
REQ-028 Requests arriving during XFER or RELEASE SHALL be evaluated only in IDLE.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, grant_o 0, last_grant NUM_REQ-1 so requester 0 wins first, counters 0, valid_o 0, data_o 0, req_ready_o 0, busy_o 1, timeout_o 0.
REQ-030 Reset mid-burst SHALL abandon the burst; no beat is issued in the reset cycle.

Configuration
REQ-031 With macro ARB_TIMEOUT_EN defined: in XFER, count consecutive no-beat cycles; reaching TIMEOUT_CYC -> RELEASE with timeout_o=1 for that one cycle; any beat clears the stall count.
REQ-032 Without ARB_TIMEOUT_EN: no stall counter, timeout_o tied 0, and a stalled grant is held indefinitely.

Structure
REQ-033 Package link_arb_pkg SHALL hold the FSM state enum and default constants NUM_REQ, DW, BURST_MAX and TIMEOUT_CYC.
REQ-034 Sub-module rr_picker SHALL be combinational: (req vector, last_grant) -> one-hot winner plus any-request flag.

Verification
REQ-035 Reset then req_valid_i=4'b1111, all req_last_i=0, ready_i=1 -> grants 0,1,2,3,0 in order, each exactly 4 beats.
REQ-036 Requester 2 only, data 4'hA, req_last_i on beat 2 -> grant_o=4'b0100 one cycle after request, 2 beats of 4'hA, RELEASE, then re-grant.
REQ-037 Granted requester 1 drops valid for 3 cycles mid-burst -> grant held, valid_o=0, beat count unchanged, burst resumes.
REQ-038 ready_i=0 for 20 cycles with ARB_TIMEOUT_EN -> timeout_o pulses after 16 stall cycles and grant passes on; without the macro, grant is held all 20 cycles.
REQ-039 rst_n asserted during beat 2 of a burst -> all outputs take reset values immediately and requester 0 wins the first grant after release.
REQ-040 Every cycle, checker asserts: grant_o is one-hot or zero, req_ready_o is a subset of grant_o, and busy_o == !(state==XFER).
